frame_deframer: RTL

FRAME_DEFRAMER -- requirements
Module: frame_deframer

---
 rtl/frame_pkg.sv | 28 ++
 rtl/crc16_par.sv | 26 ++
 rtl/frame_deframer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame deframer slice.
//   state_t      : deframer FSM state encoding
//   CRC_POLY     : CRC-16-CCITT generator polynomial
//   DEF_HEADER   : default frame-start pattern for a 16-bit word
//   DEF_TRAILER  : default frame-end pattern for a 16-bit word
//   is_onehot16  : true when exactly one bit of a (zero-extended) field is set
package frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_CTRL,
    ST_PAYLOAD,
    ST_CRC,
    ST_TRL1,
    ST_TRL2,
    ST_DRAIN
  } state_t;

  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [31:0] DEF_HEADER  = 32'hE0E0E0E0;
  localparam logic [31:0] DEF_TRAILER = 32'h0E0E0E0E;

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/crc16_par.sv
// One DATA_W-bit step of CRC-16-CCITT (no reflection), data consumed MSB first.
//   crc_in  : CRC before this word
//   data    : word to fold into the CRC
//   crc_out : CRC after this word
module crc16_par
  import frame_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       crc_out
);

  logic fb;

  always_comb begin
    crc_out = crc_in;
    fb      = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb      = crc_out[15] ^ data[DATA_W-1-i];
      crc_out = {crc_out[14:0], 1'b0} ^ ({16{fb}} & CRC_POLY);
    end
  end

endmodule

// File: rtl/frame_deframer.sv
// Frame deframer: hunts for HEADER, reads a CTRL word (one-hot channel plus
// payload length - 1), buffers the payload while running CRC-16-CCITT over it,
// checks the CRC word and TRAILER, then replays the payload (optionally
// Gray-coded as one long number) on a valid/ready output.
//   clk_in, rst_n            : clock, asynchronous active-low reset
//   data_in/_vld/_rdy        : input word stream (rdy low only while draining)
//   out_data/out_ch/out_vld/out_last/out_rdy : payload output stream
//   crc_valid_o/crc_err/frm_err : single-cycle frame status pulses
module frame_deframer
  import frame_pkg::*;
#(
  parameter int                    DATA_W    = 16,
  parameter int                    N_CH      = 8,
  parameter int                    MAX_WORDS = 8,
  parameter logic [2*DATA_W-1:0]   HEADER    = {(DATA_W/16){DEF_HEADER}},
  parameter logic [2*DATA_W-1:0]   TRAILER   = {(DATA_W/16){DEF_TRAILER}},
  parameter int                    GRAY_EN   = 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_vld,
  output logic              data_in_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [N_CH-1:0]   out_ch,
  output logic              out_vld,
  output logic              out_last,
  input  logic              out_rdy,
  output logic              crc_valid_o,
  output logic              crc_err,
  output logic              frm_err
);

  localparam int LEN_W = $clog2(MAX_WORDS);
  localparam int IDX_W = (LEN_W > 0) ? LEN_W : 1;

  localparam logic [DATA_W-1:0] HDR_HI = HEADER[2*DATA_W-1:DATA_W];
  localparam logic [DATA_W-1:0] HDR_LO = HEADER[DATA_W-1:0];
  localparam logic [DATA_W-1:0] TRL_HI = TRAILER[2*DATA_W-1:DATA_W];
  localparam logic [DATA_W-1:0] TRL_LO = TRAILER[DATA_W-1:0];

  state_t            state;
  logic [15:0]       crc_q;
  logic [15:0]       crc_next;
  logic              crc_ok;
  logic [N_CH-1:0]   ch_q;
  logic [IDX_W-1:0]  len_m1;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              prev_lsb;
  logic [IDX_W-1:0]  ctrl_len;
  logic [15:0]       ch_ext;
  logic [DATA_W-1:0] wr_word;
  logic              accept;
  logic              buf_we;

  logic [DATA_W-1:0] pbuf [MAX_WORDS];

  assign data_in_rdy = (state != ST_DRAIN);
  assign accept      = data_in_vld && data_in_rdy;
  assign buf_we      = accept && (state == ST_PAYLOAD);
  assign ch_ext      = 16'(data_in[N_CH-1:0]);

  generate
    if (LEN_W > 0) begin : g_len
      assign ctrl_len = data_in[N_CH +: LEN_W];
    end else begin : g_nolen
      assign ctrl_len = '0;
    end
  endgenerate

  // Gray code over the whole payload as one number: each word's shifted-in
  // MSB is the previous word's LSB, so the coding is applied while storing.
  generate
    if (GRAY_EN != 0) begin : g_gray
      assign wr_word = data_in ^ {prev_lsb, data_in[DATA_W-1:1]};
    end else begin : g_plain
      assign wr_word = data_in;
    end
  endgenerate

  crc16_par #(.DATA_W(DATA_W)) u_crc (
    .crc_in  (crc_q),
    .data    (data_in),
    .crc_out (crc_next)
  );

  // Payload store; contents are don't-care outside a frame, so no reset.
  always_ff @(posedge clk_in) begin
    if (buf_we) begin
      pbuf[wr_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      crc_q       <= '0;
      crc_ok      <= 1'b0;
      ch_q        <= '0;
      len_m1      <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      prev_lsb    <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_vld     <= 1'b0;
      out_last    <= 1'b0;
      crc_valid_o <= 1'b0;
      crc_err     <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      crc_valid_o <= 1'b0;
      crc_err     <= 1'b0;
      frm_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && (data_in == HDR_HI)) begin
            state <= ST_HDR2;
          end
        end
        ST_HDR2: begin
          if (accept) begin
            if (data_in == HDR_LO) begin
              state <= ST_CTRL;
            end else if (data_in != HDR_HI) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_CTRL: begin
          if (accept) begin
            if (!is_onehot16(ch_ext)) begin
              frm_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              ch_q     <= data_in[N_CH-1:0];
              len_m1   <= ctrl_len;
              wr_idx   <= '0;
              prev_lsb <= 1'b0;
              crc_q    <= '0;
              state    <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            crc_q    <= crc_next;
            prev_lsb <= data_in[0];
            wr_idx   <= wr_idx + IDX_W'(1);
            if (wr_idx == len_m1) begin
              state <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (accept) begin
            crc_ok <= (data_in[15:0] == crc_q);
            state  <= ST_TRL1;
          end
        end
        ST_TRL1: begin
          if (accept) begin
            if (data_in == TRL_HI) begin
              state <= ST_TRL2;
            end else begin
              frm_err <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        ST_TRL2: begin
          if (accept) begin
            if (data_in != TRL_LO) begin
              frm_err <= 1'b1;
              state   <= ST_IDLE;
            end else if (!crc_ok) begin
              crc_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              crc_valid_o <= 1'b1;
              out_vld     <= 1'b1;
              out_data    <= pbuf[0];
              out_ch      <= ch_q;
              out_last    <= (len_m1 == '0);
              rd_idx      <= IDX_W'(1);
              state       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_vld && out_rdy) begin
            if (out_last) begin
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              out_data <= '0;
              out_ch   <= '0;
              state    <= ST_IDLE;
            end else begin
              out_data <= pbuf[rd_idx];
              out_last <= (rd_idx == len_m1);
              rd_idx   <= rd_idx + IDX_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
